// File: rtl/fringe_clk_scheduler.sv
// Freezes mission-clock domains on their rising edges and serialises one PUT and/or GET
// exchange per edge over the shared fringe channel, round-robin, with a per-phase watchdog.
module fringe_clk_scheduler #(
  parameter int NCLK   = 4,
  parameter int IDXW   = 2,
  parameter int WD_MAX = 10000
) (
  input  logic            clk_i,
  input  logic            rst_n,
  input  logic [NCLK-1:0] clk_h,
  input  logic            put_run_en,
  input  logic            get_run_en,
  input  logic            xfer_done,
  input  logic            xfer_ok,
  output logic            xfer_req,
  output logic            xfer_dir,
  output logic [IDXW-1:0] xfer_idx,
  output logic [NCLK-1:0] freeze_clk,
  output logic            busy,
  output logic            wdog_err
);

  localparam int WDW = $clog2(WD_MAX + 1);

  typedef enum logic [1:0] {IDLE, PUT, GET, REL} state_t;

  state_t          state;
  logic [NCLK-1:0] clk_h_d;
  logic [NCLK-1:0] pend;
  logic [NCLK-1:0] edge_det;
  logic [NCLK-1:0] idx_oh;
  logic [NCLK-1:0] rel_clr;
  logic [NCLK-1:0] hold_sel;
  logic [IDXW-1:0] rr_ptr;
  logic [IDXW-1:0] pick;
  logic [IDXW-1:0] cand;
  logic            found;
  logic            xfer_fin;
  logic            wd_hit;
  logic [WDW-1:0]  wd_cnt;

  assign edge_det = clk_h & ~clk_h_d;
  assign idx_oh   = NCLK'(1) << xfer_idx;
  assign rel_clr  = (state == REL) ? idx_oh : '0;
  assign hold_sel = busy ? idx_oh : '0;
  assign xfer_fin = xfer_req & xfer_done & xfer_ok;
  assign wd_hit   = (wd_cnt == WDW'(WD_MAX));

  // Scan starts one past the last served domain so every domain gets a turn.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = rr_ptr;
    for (int k = 0; k < NCLK; k++) begin
      cand = (cand == IDXW'(NCLK - 1)) ? '0 : cand + IDXW'(1);
      if (!found && pend[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      clk_h_d    <= '0;
      pend       <= '0;
      freeze_clk <= '0;
      rr_ptr     <= IDXW'(NCLK - 1);
      xfer_req   <= 1'b0;
      xfer_dir   <= 1'b0;
      xfer_idx   <= '0;
      busy       <= 1'b0;
      wdog_err   <= 1'b0;
      wd_cnt     <= '0;
    end else begin
      clk_h_d    <= clk_h;
      // A new edge on the domain being released wins over the release clear.
      pend       <= (pend & ~rel_clr) | edge_det;
      freeze_clk <= ((pend | hold_sel) & ~rel_clr) | edge_det;

      case (state)
        IDLE: begin
          if (found) begin
            xfer_idx <= pick;
            rr_ptr   <= pick;
            busy     <= 1'b1;
            wd_cnt   <= '0;
            if (put_run_en) begin
              state    <= PUT;
              xfer_req <= 1'b1;
              xfer_dir <= 1'b0;
            end else if (get_run_en) begin
              state    <= GET;
              xfer_req <= 1'b1;
              xfer_dir <= 1'b1;
            end else begin
              state <= REL;
            end
          end
        end

        PUT, GET: begin
          if (xfer_fin) begin
            xfer_req <= 1'b0;
            wd_cnt   <= '0;
            if (state == PUT && get_run_en) begin
              state    <= GET;
              xfer_dir <= 1'b1;
            end else begin
              state <= REL;
            end
          end else if (wd_hit) begin
            wdog_err <= 1'b1;
            xfer_req <= 1'b0;
            state    <= REL;
          end else begin
            if (wd_cnt != '1) wd_cnt <= wd_cnt + WDW'(1);
            // GET entered from PUT re-raises the request after a one-cycle gap.
            if (!xfer_req) xfer_req <= 1'b1;
          end
        end

        REL: begin
          state    <= IDLE;
          busy     <= 1'b0;
          xfer_dir <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fringe_clk_scheduler.sv
// Bench for fringe_clk_scheduler: round-robin vector table, cycle-exact corner sequences
// and a randomized run against a set-based model of pending domains and service order.
module tb_fringe_clk_scheduler;

  localparam int NCLK   = 4;
  localparam int IDXW   = 2;
  localparam int WD_MAX = 20;

  logic            clk_i = 1'b0;
  logic            rst_n = 1'b0;
  logic [NCLK-1:0] clk_h = '0;
  logic            put_run_en = 1'b0;
  logic            get_run_en = 1'b0;
  logic            xfer_done = 1'b0;
  logic            xfer_ok = 1'b0;
  logic            xfer_req;
  logic            xfer_dir;
  logic [IDXW-1:0] xfer_idx;
  logic [NCLK-1:0] freeze_clk;
  logic            busy;
  logic            wdog_err;

  int checks = 0;
  int errors = 0;
  bit resp_on = 1'b0;
  bit rand_fail = 1'b0;
  bit failed_once = 1'b0;
  int req_age = 0;
  int force_fail = 0;

  typedef struct {
    logic       put;
    logic       get;
    logic [3:0] mask;
    int         n;
    logic [7:0] order;
  } vec_t;

  vec_t vecs [5];

  fringe_clk_scheduler #(.NCLK(NCLK), .IDXW(IDXW), .WD_MAX(WD_MAX)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .clk_h(clk_h),
    .put_run_en(put_run_en), .get_run_en(get_run_en),
    .xfer_done(xfer_done), .xfer_ok(xfer_ok),
    .xfer_req(xfer_req), .xfer_dir(xfer_dir), .xfer_idx(xfer_idx),
    .freeze_clk(freeze_clk), .busy(busy), .wdog_err(wdog_err)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock; afterwards the transport model answers every request 3 cycles later.
  task automatic cyc();
    @(posedge clk_i);
    #2;
    xfer_done = 1'b0;
    xfer_ok   = 1'b0;
    if (xfer_req && resp_on) begin
      req_age++;
      if (req_age == 3) begin
        req_age   = 0;
        xfer_done = 1'b1;
        if (force_fail > 0) begin
          xfer_ok = 1'b0;
          force_fail--;
        end else if (rand_fail && !failed_once && $urandom_range(3) == 0) begin
          xfer_ok     = 1'b0;
          failed_once = 1'b1;
        end else begin
          xfer_ok = 1'b1;
        end
      end
    end else begin
      req_age     = 0;
      failed_once = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clk_h = '0; put_run_en = 1'b0; get_run_en = 1'b0;
    xfer_done = 1'b0; xfer_ok = 1'b0; req_age = 0; failed_once = 1'b0; force_fail = 0;
    repeat (3) @(posedge clk_i);
    #2;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_req"},    int'(xfer_req), 0);
    chk({tag, "_dir"},    int'(xfer_dir), 0);
    chk({tag, "_idx"},    int'(xfer_idx), 0);
    chk({tag, "_freeze"}, int'(freeze_clk), 0);
    chk({tag, "_busy"},   int'(busy), 0);
    chk({tag, "_wdog"},   int'(wdog_err), 0);
  endtask

  // Runs until nothing is pending or frozen, logging served domains and request rises.
  task automatic run_idle(input string tag, output int ns, output logic [7:0] ord,
                          output int nr, output int ng);
    int   quiet;
    logic pb, pr;
    quiet = 0; pb = busy; pr = xfer_req; ns = 0; ord = '0; nr = 0; ng = 0;
    for (int c = 0; c < 400 && quiet < 3; c++) begin
      cyc();
      clk_h = '0;
      if (busy && !pb) begin
        if (ns < 4) ord[2*ns +: 2] = xfer_idx;
        ns++;
      end
      if (xfer_req && !pr) begin
        nr++;
        if (xfer_dir) ng++;
      end
      quiet = (!busy && freeze_clk == '0) ? quiet + 1 : 0;
      pb = busy;
      pr = xfer_req;
    end
    chk({tag, "_idle_reached"}, int'(quiet >= 3), 1);
  endtask

  function automatic int next_dom(input logic [3:0] p, input int r);
    for (int k = 1; k <= NCLK; k++)
      if (p[(r + k) % NCLK]) return (r + k) % NCLK;
    return -1;
  endfunction

  initial begin
    int         ns, nr, ng, cnt, hi, rq, expd, rrm, served, rises, svp, svg;
    logic [7:0] ord;
    logic [3:0] mp, hp, ed, fexp;
    logic       pb, pr;

    // put, get, edge mask, services expected, order (2 bits per service, first in [1:0])
    vecs[0] = '{put: 1'b1, get: 1'b0, mask: 4'b1010, n: 2, order: 8'h0D};
    vecs[1] = '{put: 1'b1, get: 1'b0, mask: 4'b1011, n: 3, order: 8'h34};
    vecs[2] = '{put: 1'b1, get: 1'b1, mask: 4'b0100, n: 1, order: 8'h02};
    vecs[3] = '{put: 1'b0, get: 1'b1, mask: 4'b0110, n: 2, order: 8'h09};
    vecs[4] = '{put: 1'b0, get: 1'b0, mask: 4'b1111, n: 4, order: 8'h93};

    do_reset();
    check_zero("in_reset");
    rst_n = 1'b1;
    cyc();
    check_zero("post_reset");

    // Single edge on domain 0 with both phases enabled.
    put_run_en = 1'b1; get_run_en = 1'b1; resp_on = 1'b1;
    clk_h = 4'b0001;
    cyc();
    clk_h = '0;
    chk("b_freeze_t1", int'(freeze_clk[0]), 1);
    chk("b_req_t1", int'(xfer_req), 0);
    chk("b_busy_t1", int'(busy), 0);
    cyc();
    chk("b_req_t2", int'(xfer_req), 1);
    chk("b_dir_put", int'(xfer_dir), 0);
    chk("b_idx", int'(xfer_idx), 0);
    chk("b_busy_t2", int'(busy), 1);
    run_idle("b", ns, ord, nr, ng);
    chk("b_get_rises", nr, 1);
    chk("b_get_dir", ng, 1);

    for (int v = 0; v < 5; v++) begin
      put_run_en = vecs[v].put; get_run_en = vecs[v].get;
      clk_h = vecs[v].mask;
      run_idle($sformatf("vec%0d", v), ns, ord, nr, ng);
      chk($sformatf("vec%0d_served", v), ns, vecs[v].n);
      for (int k = 0; k < vecs[v].n; k++)
        chk($sformatf("vec%0d_order%0d", v, k), int'(ord[2*k +: 2]), int'(vecs[v].order[2*k +: 2]));
      chk($sformatf("vec%0d_reqs", v), nr, vecs[v].n * (int'(vecs[v].put) + int'(vecs[v].get)));
      chk($sformatf("vec%0d_gets", v), ng, vecs[v].n * int'(vecs[v].get));
    end

    // Failed transfer is retried with the request held.
    put_run_en = 1'b1; get_run_en = 1'b0; force_fail = 1;
    clk_h = 4'b0010;
    cnt = 0;
    for (int c = 0; c < 60 && cnt == 0; c++) begin
      cyc();
      clk_h = '0;
      if (xfer_done && !xfer_ok) begin
        cyc();
        cnt = 1;
        chk("c_req_held", int'(xfer_req), 1);
        chk("c_dir_put", int'(xfer_dir), 0);
        chk("c_busy", int'(busy), 1);
      end
    end
    chk("c_fail_seen", cnt, 1);
    run_idle("c", ns, ord, nr, ng);
    chk("c_no_new_req", nr, 0);
    chk("c_no_wdog", int'(wdog_err), 0);

    // Transport never answers: watchdog aborts the PUT.
    resp_on = 1'b0;
    clk_h = 4'b0100;
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      cyc();
      clk_h = '0;
      if (xfer_req) cnt++;
      if (wdog_err) break;
    end
    chk("d_wdog_set", int'(wdog_err), 1);
    chk("d_req_cycles", cnt, WD_MAX + 1);
    chk("d_req_drop", int'(xfer_req), 0);
    cyc();
    chk("d_busy_after_rel", int'(busy), 0);
    chk("d_freeze_rel", int'(freeze_clk[2]), 0);
    xfer_done = 1'b1; xfer_ok = 1'b1;
    cyc();
    chk("d_late_done_busy", int'(busy), 0);
    chk("d_late_done_req", int'(xfer_req), 0);
    resp_on = 1'b1;
    clk_h = 4'b0100;
    run_idle("d2", ns, ord, nr, ng);
    chk("d2_served", ns, 1);
    chk("d2_idx", int'(ord[1:0]), 2);
    chk("d2_reqs", nr, 1);
    chk("d2_wdog_sticky", int'(wdog_err), 1);

    // No phases enabled: freeze covers only the pend->release window.
    put_run_en = 1'b0; get_run_en = 1'b0;
    clk_h = 4'b0100;
    hi = 0; rq = 0;
    for (int c = 0; c < 8; c++) begin
      cyc();
      clk_h = '0;
      if (freeze_clk[2]) hi++;
      if (xfer_req) rq++;
    end
    chk("e_freeze_window", hi, 2);
    chk("e_no_req", rq, 0);

    // New edge on the served domain during release keeps it pending and frozen.
    put_run_en = 1'b1; get_run_en = 1'b0;
    clk_h = 4'b1000;
    cnt = 0; hi = 0;
    for (int c = 0; c < 60 && hi == 0; c++) begin
      cyc();
      clk_h = '0;
      if (xfer_req) cnt = 1;
      else if (busy && cnt == 1) hi = 1;
    end
    chk("f_rel_found", hi, 1);
    clk_h = 4'b1000;
    cyc();
    clk_h = '0;
    chk("f_freeze_kept", int'(freeze_clk[3]), 1);
    chk("f_busy_rel", int'(busy), 0);
    cyc();
    chk("f_reserved_busy", int'(busy), 1);
    chk("f_reserved_idx", int'(xfer_idx), 3);
    run_idle("f", ns, ord, nr, ng);

    // Asynchronous reset in the middle of a GET.
    put_run_en = 1'b0; get_run_en = 1'b1; resp_on = 1'b0;
    clk_h = 4'b0010;
    cnt = 0;
    for (int c = 0; c < 20 && cnt == 0; c++) begin
      cyc();
      clk_h = '0;
      if (xfer_req && xfer_dir) cnt = 1;
    end
    chk("g_get_active", cnt, 1);
    #1 rst_n = 1'b0;
    #1;
    check_zero("g_async");
    repeat (2) @(posedge clk_i);
    #2;
    rst_n = 1'b1; req_age = 0; resp_on = 1'b1;
    clk_h = 4'b0101;
    cyc();
    clk_h = '0;
    cyc();
    chk("g_first_busy", int'(busy), 1);
    chk("g_first_idx", int'(xfer_idx), 0);
    run_idle("g", ns, ord, nr, ng);
    chk("g_second_served", ns, 1);
    chk("g_second_idx", int'(ord[1:0]), 2);

    // Randomized edges, enables and occasional failed transfers against the set model.
    do_reset();
    rst_n = 1'b1;
    resp_on = 1'b1; rand_fail = 1'b1;
    mp = '0; rrm = NCLK - 1; served = 0; rises = 0; svp = 0; svg = 0;
    pb = 1'b0; pr = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!busy) begin
        put_run_en = 1'($urandom_range(1));
        get_run_en = 1'($urandom_range(1));
      end
      hp = clk_h;
      for (int i = 0; i < NCLK; i++)
        if ($urandom_range(7) == 0) clk_h[i] = ~clk_h[i];
      ed = clk_h & ~hp;
      cyc();
      if (busy && !pb) begin
        expd = next_dom(mp, rrm);
        chk("rnd_pick", int'(xfer_idx), expd);
        rrm = expd; served = expd; rises = 0;
        svp = int'(put_run_en); svg = int'(get_run_en);
      end
      if (xfer_req && !pr) rises++;
      if (!busy && pb) begin
        chk("rnd_phases", rises, svp + svg);
        mp = mp & ~(4'b0001 << served);
      end
      mp = mp | ed;
      fexp = mp | (busy ? (4'b0001 << served) : 4'b0000);
      chk("rnd_freeze", int'(freeze_clk), int'(fexp));
      pb = busy;
      pr = xfer_req;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
